mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
- Multicycle successor to the single-cycle main/aux decoders. One Moore/Mealy FSM sequences each MIPS instruction over several cycles through the shared ALU, memory port and IR.
- Adds a memory-ready handshake, a parametrised multi-cycle MULTU occupancy counter, and a retire pulse.
- Sits between the IR opcode/funct fields and the multicycle datapath. The ALU control field alu_op still feeds the existing auxdec.

Parameters:
- MUL_LAT, 4, cycles the MULT state occupies (legal range 1..16).
- CNT_W, 4, width of the MULT down-counter; must satisfy 2**CNT_W >= MUL_LAT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes access this cycle
- pc_we  out  1  PC write enable (unconditional)
- branch  out  1  conditional PC write; datapath ANDs with zero
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  IR write enable
- we_dm  out  1  data memory write
- we_reg  out  1  register file write
- reg_dst  out  1  1 = rd, 0 = rt
- dm2reg  out  1  writeback select MDR
- link  out  1  write PC (already +4) to $31
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- alu_op  out  2  to auxdec
- pc_src  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = A (jr)
- hilo_start  out  1  one-cycle multiplier launch
- hilo_we  out  1  HI/LO capture
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: state = FETCH (0), counter = 0, state_dbg = 0. All outputs are 0 except the FETCH decode (alu_src_b = 01, retire = 0).
- Outputs are combinational from state, plus mem_ready where noted. Every output not listed for a state is 0. Transitions happen on rising clk.
- Encoding and per-state outputs:
  - FETCH 0: iord 0, alu_src_b 01. When mem_ready = 1: ir_we = 1, pc_we = 1, go to DECODE. Otherwise stay in FETCH with ir_we = pc_we = 0.
  - DECODE 1: alu_src_b 11. Dispatch on opcode:
    - 000000: funct 001000 -> JR; funct 011001 -> MULT; all other funct -> RTEX.
    - 100011 / 101011 -> MEMADR; 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP; 000011 -> JAL.
    - Any other opcode -> illegal handling (see Optional Feature).
  - MEMADR 2: alu_src_a 1, alu_src_b 10. LW -> MEMRD; SW -> MEMWR.
  - MEMRD 3: iord 1. Hold until mem_ready, then -> MEMWB.
  - MEMWB 4: we_reg 1, dm2reg 1, retire 1 -> FETCH.
  - MEMWR 5: iord 1, we_dm 1 held every cycle while waiting. On mem_ready: retire 1 -> FETCH.
  - RTEX 6: alu_src_a 1, alu_op 10 -> RTWB.
  - RTWB 7: we_reg 1, reg_dst 1, alu_op 10, retire 1 -> FETCH.
  - BEQ 8: alu_src_a 1, alu_op 01, branch 1, pc_src 01, retire 1 -> FETCH.
  - ADDIEX 9: alu_src_a 1, alu_src_b 10 -> ADDIWB.
  - ADDIWB 10: we_reg 1 -> FETCH with retire 1.
  - JUMP 11: pc_src 10, pc_we 1, retire 1 -> FETCH.
  - JAL 12: pc_src 10, pc_we 1, we_reg 1, link 1, retire 1 -> FETCH.
  - JR 13: pc_src 11, pc_we 1, retire 1 -> FETCH.
  - MULT 14:
    - DECODE->MULT transition loads counter = MUL_LAT-1.
    - hilo_start = 1 only on the first MULT cycle.
    - Counter decrements each cycle while nonzero.
    - When counter == 0: hilo_we = 1, retire = 1, go to FETCH.
    - MUL_LAT = 1: start, hilo_we and retire all assert in the same single cycle.
  - TRAP 15: see Optional Feature.
- Cycle counts with mem_ready tied to 1: R-type 4, ADDI 4, LW 5, SW 4, BEQ 3, J/JAL/JR 3, MULTU 2+MUL_LAT.
- Each cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- Async reset asserted mid-instruction (including mid-MULT or mid-stall) returns to FETCH immediately and clears the counter; no retire pulse is produced.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE -> TRAP. TRAP asserts no enables; it remains until rst_n. state_dbg = 15.
- Undefined: an illegal opcode in DECODE -> FETCH with retire = 1 (executes as a NOP). State 15 is unreachable.

Test Plan:
- Reset low with mem_ready = 1, then release -> state_dbg = 0. The first edge gives ir_we = pc_we = 1 and moves to DECODE; all other enables stay 0.
- LW (opcode 100011) with mem_ready low for 2 cycles in MEMRD -> state sequence 0,1,2,3,3,3,4,0. we_reg and dm2reg assert only in state 4; retire lands on cycle 7.
- MULTU (funct 011001) with MUL_LAT = 4 -> hilo_start on the first state-14 cycle, hilo_we on the 4th. Total 6 cycles; repeat with MUL_LAT = 1 and get 3 cycles.
- JAL (000011) -> states 0,1,12. In state 12: pc_src = 10, pc_we = link = we_reg = 1. JR (000000/001000) -> state 13 with pc_src = 11.
- Opcode 111111: with MC_ILLEGAL_TRAP_EN, state_dbg = 15 and stays for 10 cycles. Without it, returns to 0 with one retire pulse.
- rst_n pulsed low during MULT (counter = 2) -> immediate state 0. The next MULTU runs the full MUL_LAT cycles.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS control FSM with memory handshake and MULTU occupancy counter
// Optional MC_ILLEGAL_TRAP_EN: illegal opcodes lock into TRAP instead of retiring as a NOP.
module mc_ctrl_fsm #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       branch,
  output logic       iord,
  output logic       ir_we,
  output logic       we_dm,
  output logic       we_reg,
  output logic       reg_dst,
  output logic       dm2reg,
  output logic       link,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       hilo_start,
  output logic       hilo_we,
  output logic       retire,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13, S_MULT   = 4'd14, S_TRAP   = 4'd15
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_we      = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    we_dm      = 1'b0;
    we_reg     = 1'b0;
    reg_dst    = 1'b0;
    dm2reg     = 1'b0;
    link       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    hilo_start = 1'b0;
    hilo_we    = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'b000000: begin
            if (funct == 6'b001000) state_d = S_JR;
            else if (funct == 6'b011001) begin
              state_d = S_MULT;
              cnt_d   = CNT_LOAD;
            end else state_d = S_RTEX;
          end
          6'b100011, 6'b101011: state_d = S_MEMADR;
          6'b000100:            state_d = S_BEQ;
          6'b001000:            state_d = S_ADDIEX;
          6'b000010:            state_d = S_JUMP;
          6'b000011:            state_d = S_JAL;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            retire  = 1'b1;
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        we_reg  = 1'b1;
        dm2reg  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        iord  = 1'b1;
        we_dm = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_RTEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RTWB;
      end
      S_RTWB: begin
        we_reg  = 1'b1;
        reg_dst = 1'b1;
        alu_op  = 2'b10;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_src    = 2'b01;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        we_reg  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pc_src  = 2'b10;
        pc_we   = 1'b1;
        we_reg  = 1'b1;
        link    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_src  = 2'b11;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MULT: begin
        // The counter only equals its load value on the first MULT cycle.
        hilo_start = (cnt_q == CNT_LOAD);
        if (cnt_q == '0) begin
          hilo_we = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_dbg = state_q;

endmodule
